// File: rtl/fu_div_pkg.sv
// fu_div_pkg: shared FU types, divide op set and iteration counts for fu_div.
package fu_div_pkg;
   localparam int XLEN       = 64;
   localparam int DIV_ITER_D = 64;
   localparam int DIV_ITER_W = 32;
   typedef enum logic [2:0] {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW} div_set_t;
   typedef struct packed {
      div_set_t div;
   } fu_op_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [7:0]      id;
      logic [5:0]      prd;
      logic [XLEN-1:0] rs1val;
      logic [XLEN-1:0] rs2val;
      fu_op_t          op;
   } fu_input_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [7:0]      id;
      logic [5:0]      prd;
      logic [XLEN-1:0] rdval;
   } fu_output_t;
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction
endpackage

// File: rtl/fu_div_step.sv
// fu_div_step: one combinational restoring-division iteration (r,q,d) -> (r',q').
module fu_div_step
   import fu_div_pkg::*;
(
   input  logic [XLEN-1:0] r,
   input  logic [XLEN-1:0] q,
   input  logic [XLEN-1:0] d,
   output logic [XLEN-1:0] r_n,
   output logic [XLEN-1:0] q_n
);
   // shifted partial remainder can exceed XLEN bits before the compare
   logic [XLEN:0] rs, diff;
   logic ge;
   assign rs   = {r, q[XLEN-1]};
   assign diff = rs - {1'b0, d};
   assign ge   = rs >= {1'b0, d};
   assign r_n  = ge ? diff[XLEN-1:0] : rs[XLEN-1:0];
   assign q_n  = {q[XLEN-2:0], ge};
endmodule

// File: rtl/fu_div.sv
// fu_div: iterative radix-2 RV64M divide unit (DIV/DIVU/REM/REMU + W forms).
// FU_DIV_EARLY_OUT_EN: resolve divide-by-zero and signed overflow at accept, skipping iteration.
module fu_div
   import fu_div_pkg::*;
#(
   parameter int ITER_D = DIV_ITER_D,
   parameter int ITER_W = DIV_ITER_W
)(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       flush_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  fu_input_t  in_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output fu_output_t out_o,
   output logic       busy_o
);
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} div_state_t;
   div_state_t state;
   logic [6:0] cnt;
   logic [XLEN-1:0] r, q, d, r_n, q_n;
   logic neg_q, neg_r, is_w_q, is_rem_q;
   logic sgn, is_w, is_rem, sa, sb;
   logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, q_fix, r_fix, res;
   assign sgn    = in_i.op.div inside {DIV, REM, DIVW, REMW};
   assign is_w   = in_i.op.div inside {DIVW, DIVUW, REMW, REMUW};
   assign is_rem = in_i.op.div inside {REM, REMU, REMW, REMUW};
   // W operands are widened to XLEN so one abs/sign path serves both widths
   assign a_ext  = is_w ? (sgn ? sext32(in_i.rs1val[31:0]) : {32'b0, in_i.rs1val[31:0]}) : in_i.rs1val;
   assign b_ext  = is_w ? (sgn ? sext32(in_i.rs2val[31:0]) : {32'b0, in_i.rs2val[31:0]}) : in_i.rs2val;
   assign sa     = sgn & a_ext[XLEN-1];
   assign sb     = sgn & b_ext[XLEN-1];
   assign abs_a  = sa ? -a_ext : a_ext;
   assign abs_b  = sb ? -b_ext : b_ext;
   assign q_fix  = neg_q ? -q : q;
   assign r_fix  = neg_r ? -r : r;
   assign res    = is_rem_q ? r_fix : q_fix;
   assign in_ready_o = (state == IDLE) && !flush_i;
   assign busy_o     = state != IDLE;
`ifdef FU_DIV_EARLY_OUT_EN
   logic early;
   logic [XLEN-1:0] early_val;
   assign early = (abs_b == '0) ||
                  (sa && b_ext == '1 && a_ext == (is_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
   assign early_val = (abs_b == '0) ?
                      (is_rem ? (is_w ? sext32(in_i.rs1val[31:0]) : in_i.rs1val) : '1) :
                      (is_rem ? '0 : a_ext);
`endif
   fu_div_step u_step (.r(r), .q(q), .d(d), .r_n(r_n), .q_n(q_n));
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         is_w_q      <= 1'b0;
         is_rem_q    <= 1'b0;
         out_valid_o <= 1'b0;
         out_o       <= '0;
      end else if (flush_i) begin
         state       <= IDLE;
         out_valid_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid_i) begin
               out_o.pc  <= in_i.pc;
               out_o.id  <= in_i.id;
               out_o.prd <= in_i.prd;
               is_w_q    <= is_w;
               is_rem_q  <= is_rem;
               neg_q     <= (sa ^ sb) && (abs_b != '0);
               neg_r     <= sa;
               r         <= '0;
               // W dividends sit in the top half so 32 shifts bring them through
               q         <= is_w ? {abs_a[31:0], 32'b0} : abs_a;
               d         <= abs_b;
               cnt       <= is_w ? 7'(ITER_W) : 7'(ITER_D);
`ifdef FU_DIV_EARLY_OUT_EN
               if (early) begin
                  out_o.rdval <= early_val;
                  out_valid_o <= 1'b1;
                  state       <= DONE;
               end else
`endif
               state <= CALC;
            end
            CALC: begin
               r     <= r_n;
               q     <= q_n;
               cnt   <= cnt - 7'd1;
               state <= (cnt == 7'd1) ? FIXUP : CALC;
            end
            FIXUP: begin
               out_o.rdval <= is_w_q ? sext32(res[31:0]) : res;
               out_valid_o <= 1'b1;
               state       <= DONE;
            end
            DONE: if (out_ready_i) begin
               out_valid_o <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
